// File: rtl/video_in_pack_fifo_if.sv
// Camera-side and store-side signals of the video_in pack FIFO.
// The camera/store side drives through master; the FIFO block uses slave.
interface video_in_pack_fifo_if #(
  parameter int FIFO_DEPTH = 64
) ();
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]         pixel_in;
  logic               line_valid;
  logic               frame_valid;
  logic               r_ack;
  logic [31:0]        data_fifo;
  logic               nb_pack_available;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               frame_err;

  modport master (
    output pixel_in, line_valid, frame_valid, r_ack,
    input  data_fifo, nb_pack_available, level, overflow, frame_err
  );

  modport slave (
    input  pixel_in, line_valid, frame_valid, r_ack,
    output data_fifo, nb_pack_available, level, overflow, frame_err
  );
endinterface

// File: rtl/video_in_pack_fifo.sv
// Packs 4 luma pixels per 32-bit little-endian word and buffers them in a
// show-ahead FIFO for the store stage. Frames are only accepted from a frame_valid rise.
module video_in_pack_fifo #(
  parameter int p_WIDTH    = 640,
  parameter int p_HEIGHT   = 480,
  parameter int NB_PACK    = 16,
  parameter int FIFO_DEPTH = 64
) (
  input logic                clk,
  input logic                RST,
  video_in_pack_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [19:0]   FRAME_PIX = 20'(p_WIDTH * p_HEIGHT);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PACK_LVL  = LW'(NB_PACK);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {SYNC, WAIT_FRAME, ACTIVE} state_t;

  state_t         state_q, state_nxt;
  logic           fv_p1;
  logic [1:0]     byte_idx_q;
  logic [19:0]    pix_cnt_q;
  logic [23:0]    pack_p0;
  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q, level_nxt;
  logic           nb_q, overflow_q, frame_err_q;

  logic frame_start, frame_end, pix_vld, push, pop, wr_en, full;

  always_comb begin
    state_nxt   = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      SYNC:       if (!bus.frame_valid) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (bus.frame_valid && !fv_p1) begin
        state_nxt   = ACTIVE;
        frame_start = 1'b1;
      end
      ACTIVE:     if (!bus.frame_valid) begin
        state_nxt = WAIT_FRAME;
        frame_end = 1'b1;
      end
      default:    state_nxt = SYNC;
    endcase

    pix_vld = (state_q == ACTIVE) && bus.frame_valid && bus.line_valid;
    push    = pix_vld && (byte_idx_q == 2'd3);
    full    = (level_q == FULL_LVL);
    pop     = bus.r_ack && (level_q != '0);
    // A full FIFO still takes the word when the same cycle frees a slot.
    wr_en   = push && (!full || bus.r_ack);

    level_nxt = level_q;
    if (wr_en && !pop)      level_nxt = level_q + LVL_ONE;
    else if (!wr_en && pop) level_nxt = level_q - LVL_ONE;
  end

  // Control state: FSM, counters, pointers, flags
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= SYNC;
      fv_p1       <= 1'b0;
      byte_idx_q  <= 2'd0;
      pix_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      nb_q        <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      fv_p1   <= bus.frame_valid;
      if (frame_start) begin
        pix_cnt_q   <= '0;
        byte_idx_q  <= 2'd0;
        overflow_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end else if (pix_vld) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + 20'd1;
      end
      if (frame_end && ((pix_cnt_q != FRAME_PIX) || (byte_idx_q != 2'd0)))
        frame_err_q <= 1'b1;
      if (push && full && !bus.r_ack) overflow_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_nxt;
      nb_q    <= (level_nxt >= PACK_LVL);
    end
  end

  // Datapath: pixel gathering and word storage
  always_ff @(posedge clk) begin
    if (pix_vld) begin
      case (byte_idx_q)
        2'd0:    pack_p0[7:0]   <= bus.pixel_in;
        2'd1:    pack_p0[15:8]  <= bus.pixel_in;
        2'd2:    pack_p0[23:16] <= bus.pixel_in;
        default: ;
      endcase
    end
    if (wr_en) mem[wr_ptr_q] <= {bus.pixel_in, pack_p0};
  end

  assign bus.data_fifo         = mem[rd_ptr_q];
  assign bus.level             = level_q;
  assign bus.nb_pack_available = nb_q;
  assign bus.overflow          = overflow_q;
  assign bus.frame_err         = frame_err_q;
endmodule

// File: tb/tb_video_in_pack_fifo.sv
// Directed bench for video_in_pack_fifo on a 16x4 frame (16 words) with an 8-word FIFO.
module tb_video_in_pack_fifo;
  localparam int W     = 16;
  localparam int H     = 4;
  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int WORDS = W * H / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] got[$];
  bit   frame_done;

  video_in_pack_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  video_in_pack_fifo #(
    .p_WIDTH(W), .p_HEIGHT(H), .NB_PACK(NB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word k of a frame whose pixel n carries value n[7:0].
  function automatic logic [31:0] exp_word(input int k);
    int b;
    b = 4 * k;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input int nlines, input int extra);
    int idx;
    int len;
    idx = 0;
    bus.frame_valid = 1'b1;
    cyc(2);
    for (int l = 0; l < nlines; l++) begin
      len = W + ((l == nlines - 1) ? extra : 0);
      for (int p = 0; p < len; p++) begin
        bus.line_valid = 1'b1;
        bus.pixel_in   = 8'(idx);
        idx++;
        cyc(1);
      end
      bus.line_valid = 1'b0;
      cyc(4);
    end
    cyc(2);
    bus.frame_valid = 1'b0;
    cyc(3);
  endtask

  task automatic store_model();
    int guard;
    guard = 0;
    while (guard < 5000) begin
      if (bus.nb_pack_available) begin
        cyc(3);
        for (int i = 0; i < NB; i++) begin
          bus.r_ack = 1'b1;
          got.push_back(bus.data_fifo);
          cyc(1);
        end
        bus.r_ack = 1'b0;
      end else if (frame_done) begin
        break;
      end else begin
        cyc(1);
      end
      guard++;
    end
    n_checks++;
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL store_timeout: guard %0d reached, required < 5000", guard);
    end
  endtask

  task automatic drain(input string name, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      bus.r_ack = 1'b1;
      n_checks++;
      if (bus.data_fifo !== exp_word(first + k)) begin
        n_fail++;
        $display("FAIL %s_word%0d: got %h required %h", name, k, bus.data_fifo, exp_word(first + k));
      end
      cyc(1);
    end
    bus.r_ack = 1'b0;
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++;
      $display("FAIL %s_level: got %0d required 0", name, bus.level);
    end
  endtask

  task automatic run_store_frame(input string name, input int nlines, input int extra,
                                 input int exp_words, input logic exp_err);
    got.delete();
    frame_done = 1'b0;
    fork
      begin
        drive_frame(nlines, extra);
        frame_done = 1'b1;
      end
      store_model();
    join
    n_checks++;
    if (got.size() !== exp_words) begin
      n_fail++;
      $display("FAIL %s_count: got %0d words required %0d", name, got.size(), exp_words);
    end
    for (int i = 0; i < got.size() && i < exp_words; i++) begin
      n_checks++;
      if (got[i] !== exp_word(i)) begin
        n_fail++;
        $display("FAIL %s_word%0d: got %h required %h", name, i, got[i], exp_word(i));
      end
    end
    n_checks++;
    if (bus.frame_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_frame_err: got %b required %b", name, bus.frame_err, exp_err);
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b required 0", name, bus.overflow);
    end
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++;
      $display("FAIL %s_level: got %0d required 0", name, bus.level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_checks++;
    if ({bus.level, bus.nb_pack_available, bus.overflow, bus.frame_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: level %0d nb %b ovf %b ferr %b, required all 0",
               bus.level, bus.nb_pack_available, bus.overflow, bus.frame_err);
    end
    rst = 1'b0;
    cyc(2);
  endtask

  task automatic test_fill_overflow();
    drive_frame(H, 0);
    n_checks++;
    if (bus.level !== 4'd8) begin
      n_fail++;
      $display("FAIL fill_level: got %0d required 8", bus.level);
    end
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_overflow: got %b required 1", bus.overflow);
    end
    n_checks++;
    if (bus.nb_pack_available !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_nb: got %b required 1", bus.nb_pack_available);
    end
    n_checks++;
    if (bus.data_fifo !== 32'h0302_0100) begin
      n_fail++;
      $display("FAIL fill_head: got %h required 03020100", bus.data_fifo);
    end
    n_checks++;
    if (bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_frame_err: got %b required 0", bus.frame_err);
    end
    drain("fill", 0, DEPTH);
  endtask

  task automatic test_store_frame();
    run_store_frame("store", H, 0, WORDS, 1'b0);
  endtask

  task automatic test_full_push_pop();
    bus.frame_valid = 1'b1;
    cyc(2);
    for (int p = 0; p < 36; p++) begin
      bus.line_valid = 1'b1;
      bus.pixel_in   = 8'(p);
      bus.r_ack      = (p == 35);
      cyc(1);
    end
    bus.line_valid = 1'b0;
    bus.r_ack      = 1'b0;
    n_checks++;
    if (bus.level !== 4'd8) begin
      n_fail++;
      $display("FAIL fullpp_level: got %0d required 8", bus.level);
    end
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_overflow: got %b required 0", bus.overflow);
    end
    n_checks++;
    if (bus.data_fifo !== 32'h0706_0504) begin
      n_fail++;
      $display("FAIL fullpp_head: got %h required 07060504", bus.data_fifo);
    end
    bus.frame_valid = 1'b0;
    cyc(3);
    n_checks++;
    if (bus.frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_frame_err: got %b required 1", bus.frame_err);
    end
    drain("fullpp", 1, DEPTH);
  endtask

  task automatic test_reset_mid_frame();
    bus.frame_valid = 1'b1;
    cyc(2);
    for (int p = 0; p < 3 * W; p++) begin
      rst            = (p >= 5 && p < 7);
      bus.line_valid = 1'b1;
      bus.pixel_in   = 8'(p + 100);
      cyc(1);
    end
    bus.line_valid = 1'b0;
    cyc(2);
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++;
      $display("FAIL midrst_level: got %0d required 0", bus.level);
    end
    bus.frame_valid = 1'b0;
    cyc(3);
    n_checks++;
    if (bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_frame_err: got %b required 0", bus.frame_err);
    end
    run_store_frame("midrst", H, 0, WORDS, 1'b0);
  endtask

  task automatic test_frame_errors();
    run_store_frame("short", H - 1, 0, (H - 1) * W / 4, 1'b1);
    run_store_frame("long", H, 2, WORDS, 1'b1);
    run_store_frame("good", H, 0, WORDS, 1'b0);
  endtask

  task automatic test_empty_pop();
    bus.frame_valid = 1'b1;
    cyc(2);
    bus.r_ack = 1'b1;
    cyc(3);
    bus.r_ack = 1'b0;
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++;
      $display("FAIL empty_level: got %0d required 0", bus.level);
    end
    for (int p = 0; p < 4; p++) begin
      bus.line_valid = 1'b1;
      bus.pixel_in   = 8'(p);
      cyc(1);
    end
    bus.line_valid = 1'b0;
    n_checks++;
    if (bus.level !== 4'd1) begin
      n_fail++;
      $display("FAIL empty_push_level: got %0d required 1", bus.level);
    end
    n_checks++;
    if (bus.data_fifo !== 32'h0302_0100) begin
      n_fail++;
      $display("FAIL empty_push_head: got %h required 03020100", bus.data_fifo);
    end
    bus.frame_valid = 1'b0;
    cyc(3);
    drain("empty", 0, 1);
  endtask

  initial begin
    bus.pixel_in    = 8'd0;
    bus.line_valid  = 1'b0;
    bus.frame_valid = 1'b0;
    bus.r_ack       = 1'b0;
    frame_done      = 1'b0;
    test_reset();
    test_fill_overflow();
    test_store_frame();
    test_full_push_pop();
    test_reset_mid_frame();
    test_frame_errors();
    test_empty_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
